// File: rtl/pwm_pkg.sv
// Shared constants and types for the multichannel PWM block: register map
// offsets, control bit positions and the alignment mode enum.
package pwm_pkg;

  localparam int DUTY_BASE  = 0;
  localparam int PERIOD_OFS = 0;
  localparam int CTRL_OFS   = 1;

  localparam int CTRL_RUN_BIT  = 0;
  localparam int CTRL_MODE_BIT = 1;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwm_mode_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow and active duty registers plus the registered
// output comparator with its enable gating.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             duty_wr,
  input  logic [CNT_W-1:0] wr_data,
  input  logic             load,
  input  logic [CNT_W-1:0] cnt,
  input  logic             en_out,
  input  logic             en_pwm,
  output logic             out
);

  logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
  logic [CNT_W-1:0] duty_act_q, duty_act_d;
  logic             out_d;

  always_comb begin
    duty_sh_d  = duty_wr ? wr_data : duty_sh_q;
    // Active duty takes the post-write shadow so a boundary-cycle write lands at once.
    duty_act_d = load ? duty_sh_d : duty_act_q;
    out_d      = 1'b0;
    if (en_out) begin
      out_d = en_pwm ? (cnt < duty_act_q) : 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_sh_q  <= '0;
      duty_act_q <= '0;
      out        <= 1'b0;
    end else begin
      duty_sh_q  <= duty_sh_d;
      duty_act_q <= duty_act_d;
      out        <= out_d;
    end
  end

endmodule

// File: rtl/pwm_multichannel.sv
// Multichannel PWM top: register decode, shared counter, period/mode shadows
// and boundary detection. Define PWM_CENTER_ALIGN_EN to build center-aligned mode.
module pwm_multichannel
  import pwm_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int CNT_W  = 8,
  parameter int ADDR_W = $clog2(NUM_CH + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CNT_W-1:0]  wr_data,
  input  logic [NUM_CH-1:0] en_out,
  input  logic [NUM_CH-1:0] en_pwm,
  output logic [NUM_CH-1:0] out,
  output logic              period_tick
);

  localparam logic [ADDR_W-1:0] PERIOD_ADDR = ADDR_W'(NUM_CH + PERIOD_OFS);
  localparam logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(NUM_CH + CTRL_OFS);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_sh_q, period_sh_d;
  logic [CNT_W-1:0] period_act_q, period_act_d;
  logic             run_q, run_d;
  logic             tick_q, tick_d;
  logic             boundary;
  logic             load_act;
  logic             ctrl_wr;

  assign ctrl_wr = wr_en && (wr_addr == CTRL_ADDR);

  always_comb begin
    period_sh_d = period_sh_q;
    run_d       = run_q;
    if (wr_en && (wr_addr == PERIOD_ADDR)) begin
      period_sh_d = wr_data;
    end
    if (ctrl_wr) begin
      run_d = wr_data[CTRL_RUN_BIT];
    end
  end

`ifdef PWM_CENTER_ALIGN_EN
  pwm_mode_e mode_sh_q, mode_sh_d;
  pwm_mode_e mode_act_q, mode_act_d;
  logic      dir_q, dir_d;

  always_comb begin
    mode_sh_d = mode_sh_q;
    if (ctrl_wr) begin
      mode_sh_d = pwm_mode_e'(wr_data[CTRL_MODE_BIT]);
    end

    // A zero-length center period degenerates to an edge period of one cycle.
    if ((mode_act_q == MODE_CENTER) && (period_act_q != '0)) begin
      boundary = run_q && dir_q && (cnt_q == '0);
    end else begin
      boundary = run_q && (cnt_q == period_act_q);
    end
    load_act     = boundary || !run_q;
    period_act_d = load_act ? period_sh_d : period_act_q;
    mode_act_d   = load_act ? mode_sh_d : mode_act_q;
    tick_d       = boundary;

    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!run_q) begin
      cnt_d = '0;
      dir_d = 1'b0;
    end else if (boundary) begin
      dir_d = 1'b0;
      if ((mode_sh_d != mode_act_q) || (mode_sh_d == MODE_EDGE) || (period_sh_d == '0)) begin
        cnt_d = '0;
      end else begin
        cnt_d = CNT_W'(1);
      end
    end else if (mode_act_q == MODE_EDGE) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!dir_q) begin
      if (cnt_q >= period_act_q) begin
        dir_d = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_sh_q  <= MODE_EDGE;
      mode_act_q <= MODE_EDGE;
      dir_q      <= 1'b0;
    end else begin
      mode_sh_q  <= mode_sh_d;
      mode_act_q <= mode_act_d;
      dir_q      <= dir_d;
    end
  end
`else
  always_comb begin
    boundary     = run_q && (cnt_q == period_act_q);
    load_act     = boundary || !run_q;
    period_act_d = load_act ? period_sh_d : period_act_q;
    tick_d       = boundary;
    if (!run_q || boundary) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      period_sh_q  <= '0;
      period_act_q <= '0;
      run_q        <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      period_sh_q  <= period_sh_d;
      period_act_q <= period_act_d;
      run_q        <= run_d;
      tick_q       <= tick_d;
    end
  end

  assign period_tick = tick_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .duty_wr(wr_en && (wr_addr == ADDR_W'(DUTY_BASE + i))),
      .wr_data(wr_data),
      .load   (load_act),
      .cnt    (cnt_q),
      .en_out (en_out[i]),
      .en_pwm (en_pwm[i]),
      .out    (out[i])
    );
  end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Directed self-checking bench for pwm_multichannel (default parameters).
// Center-mode scenario compiles in only when PWM_CENTER_ALIGN_EN is defined.
module tb_pwm_multichannel;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [15:0] out;
  logic        period_tick;

  int checks   = 0;
  int failures = 0;

  pwm_multichannel dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .en_out     (en_out),
    .en_pwm     (en_pwm),
    .out        (out),
    .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  // Returns on the falling edge after the write has landed.
  task automatic reg_write(input int addr, input int data);
    logic [4:0] a;
    logic [7:0] d;
    a = addr[4:0];
    d = data[7:0];
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Returns on the falling edge where period_tick is seen high.
  task automatic wait_tick(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      if (period_tick === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    en_out  = '1;
    en_pwm  = '1;
    repeat (3) @(negedge clk);
    checks++;
    if (out !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_out got=%h exp=0000", out);
    end
    checks++;
    if (period_tick !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_tick got=%b exp=0", period_tick);
    end
    rst = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      checks++;
      if (period_tick !== 1'b0 || out !== 16'h0000) begin
        failures++;
        $display("[TB] FAIL idle_after_reset j=%0d tick=%b out=%h exp tick=0 out=0000", j, period_tick, out);
      end
    end
  endtask

  task automatic test_edge_basic();
    bit ok;
    logic exp_out, exp_tick;
    reg_write(0, 3);
    reg_write(16, 9);
    reg_write(17, 1);
    wait_tick(40, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL edge_tick_timeout got=none exp=tick");
    end
    for (int j = 0; j < 20; j++) begin
      if (j > 0) @(negedge clk);
      exp_out  = (j % 10 >= 1) && (j % 10 <= 3);
      exp_tick = (j % 10 == 0);
      checks++;
      if (out[0] !== exp_out || period_tick !== exp_tick) begin
        failures++;
        $display("[TB] FAIL edge_basic j=%0d out0=%b tick=%b exp out0=%b tick=%b", j, out[0], period_tick, exp_out, exp_tick);
      end
    end
  endtask

  task automatic test_duty_update();
    bit ok;
    int k;
    logic exp_out, exp_tick;
    wait_tick(40, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL update_tick_timeout got=none exp=tick");
    end
    for (int j = 0; j < 30; j++) begin
      if (j > 0) @(negedge clk);
      k = j % 10;
      if (j < 10)      exp_out = (k >= 1) && (k <= 3);
      else if (j < 20) exp_out = (k >= 1) && (k <= 7);
      else             exp_out = (k >= 1) && (k <= 2);
      exp_tick = (k == 0);
      checks++;
      if (out[0] !== exp_out || period_tick !== exp_tick) begin
        failures++;
        $display("[TB] FAIL duty_update j=%0d out0=%b tick=%b exp out0=%b tick=%b", j, out[0], period_tick, exp_out, exp_tick);
      end
      if (j == 0) begin
        wr_en   = 1'b1;
        wr_addr = 5'd0;
        wr_data = 8'd7;
      end else if (j == 19) begin
        wr_en   = 1'b1;
        wr_addr = 5'd0;
        wr_data = 8'd2;
      end else begin
        wr_en = 1'b0;
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_duty_extremes();
    bit ok;
    reg_write(0, 0);
    reg_write(1, 12);
    wait_tick(40, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL extremes_tick_timeout got=none exp=tick");
    end
    for (int j = 1; j <= 25; j++) begin
      @(negedge clk);
      checks++;
      if (out[0] !== 1'b0 || out[1] !== 1'b1) begin
        failures++;
        $display("[TB] FAIL duty_extremes j=%0d out0=%b out1=%b exp out0=0 out1=1", j, out[0], out[1]);
      end
    end
  endtask

  task automatic test_enables();
    @(negedge clk);
    en_out[1] = 1'b0;
    en_pwm[2] = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      checks++;
      if (out[1] !== 1'b0 || out[2] !== 1'b1 || out[3] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL enables j=%0d out1=%b out2=%b out3=%b exp 0 1 0", j, out[1], out[2], out[3]);
      end
    end
    en_out = '1;
    en_pwm = '1;
  endtask

  task automatic test_ignored_addr();
    bit ok;
    logic exp_out, exp_tick;
    reg_write(0, 3);
    reg_write(18, 0);
    reg_write(19, 0);
    reg_write(31, 5);
    wait_tick(40, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL ignored_tick_timeout got=none exp=tick");
    end
    for (int j = 0; j <= 10; j++) begin
      if (j > 0) @(negedge clk);
      exp_out  = (j >= 1) && (j <= 3);
      exp_tick = (j % 10 == 0);
      checks++;
      if (out[0] !== exp_out || out[1] !== 1'b1 || period_tick !== exp_tick) begin
        failures++;
        $display("[TB] FAIL ignored_addr j=%0d out0=%b out1=%b tick=%b exp out0=%b out1=1 tick=%b", j, out[0], out[1], period_tick, exp_out, exp_tick);
      end
    end
  endtask

  task automatic test_max_period();
    bit ok;
    int highs, extra;
    reg_write(16, 255);
    reg_write(0, 255);
    wait_tick(40, ok);
    if (ok) wait_tick(600, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL max_tick_timeout got=none exp=tick");
    end
    highs = 0;
    extra = 0;
    for (int j = 0; j < 256; j++) begin
      if (j > 0) @(negedge clk);
      if (out[0] === 1'b1) highs++;
      if (j > 0 && period_tick === 1'b1) extra++;
    end
    @(negedge clk);
    checks++;
    if (highs != 255) begin
      failures++;
      $display("[TB] FAIL max_highs got=%0d exp=255", highs);
    end
    checks++;
    if (extra != 0 || period_tick !== 1'b1) begin
      failures++;
      $display("[TB] FAIL max_tick_spacing extra=%0d tick_at_256=%b exp extra=0 tick=1", extra, period_tick);
    end
  endtask

  task automatic test_reset_midperiod();
    bit ok;
    logic exp_out, exp_tick;
    reg_write(16, 9);
    reg_write(0, 3);
    wait_tick(600, ok);
    if (ok) wait_tick(40, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL rstmid_tick_timeout got=none exp=tick");
    end
    reg_write(0, 7);
    reg_write(16, 4);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out !== 16'h0000 || period_tick !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset out=%h tick=%b exp out=0000 tick=0", out, period_tick);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      checks++;
      if (period_tick !== 1'b0 || out !== 16'h0000) begin
        failures++;
        $display("[TB] FAIL run_cleared j=%0d tick=%b out=%h exp tick=0 out=0000", j, period_tick, out);
      end
    end
    reg_write(16, 9);
    reg_write(17, 1);
    wait_tick(40, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL rstrun_tick_timeout got=none exp=tick");
    end
    for (int j = 0; j <= 10; j++) begin
      if (j > 0) @(negedge clk);
      exp_tick = (j % 10 == 0);
      checks++;
      if (out !== 16'h0000 || period_tick !== exp_tick) begin
        failures++;
        $display("[TB] FAIL duty_discarded j=%0d out=%h tick=%b exp out=0000 tick=%b", j, out, period_tick, exp_tick);
      end
    end
    reg_write(0, 3);
    wait_tick(40, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL rewrite_tick_timeout got=none exp=tick");
    end
    for (int j = 0; j < 10; j++) begin
      if (j > 0) @(negedge clk);
      exp_out = (j >= 1) && (j <= 3);
      checks++;
      if (out[0] !== exp_out) begin
        failures++;
        $display("[TB] FAIL duty_rewrite j=%0d out0=%b exp=%b", j, out[0], exp_out);
      end
    end
  endtask

`ifdef PWM_CENTER_ALIGN_EN
  task automatic test_center();
    bit ok;
    int c;
    logic exp_out, exp_tick;
    reg_write(16, 8);
    reg_write(0, 4);
    reg_write(17, 3);
    wait_tick(40, ok);
    if (ok) wait_tick(40, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL center_tick_timeout got=none exp=tick");
    end
    for (int j = 0; j <= 16; j++) begin
      if (j > 0) @(negedge clk);
      c        = (j <= 8) ? j : 16 - j;
      exp_out  = (c < 4);
      exp_tick = (j == 0) || (j == 16);
      checks++;
      if (out[0] !== exp_out || period_tick !== exp_tick) begin
        failures++;
        $display("[TB] FAIL center j=%0d out0=%b tick=%b exp out0=%b tick=%b", j, out[0], period_tick, exp_out, exp_tick);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_edge_basic();
    test_duty_update();
    test_duty_extremes();
    test_enables();
    test_ignored_addr();
    test_max_period();
    test_reset_midperiod();
`ifdef PWM_CENTER_ALIGN_EN
    test_center();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
